// File: rtl/ascon_inv_permutation_pkg.sv
// ascon_inv_permutation_pkg: shared types, S-box, round constants and linear-layer helpers
// Used by ascon_inv_permutation (top) and ascon_inv_permutation_round.
package ascon_inv_permutation_pkg;
  typedef struct packed {
    logic [63:0] s0, s1, s2, s3, s4;
  } state_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;
  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
  localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
  localparam int ROT_B [5] = '{28, 39, 6, 17, 41};
  // Inverse S-box derived by searching the forward table.
  function automatic logic [4:0] sbox_inv(input logic [4:0] x);
    logic [4:0] r;
    r = '0;
    for (int v = 0; v < 32; v++) if (SBOX[v] == x) r = 5'(v);
    return r;
  endfunction
  // Forward round constant for round index idx (0 -> f0, 11 -> 4b).
  function automatic logic [7:0] rc(input logic [3:0] idx);
    return 8'hf0 - {4'b0, idx} * 8'h0f;
  endfunction
  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    return (x >> n) | (x << ((64 - n) % 64));
  endfunction
  // L^-1 = L^63 = prod_j (I + R^(a*2^j) + R^(b*2^j)); squaring over GF(2) cancels cross terms.
  function automatic logic [63:0] lin_inv(input logic [63:0] x, input int a, input int b);
    logic [63:0] y;
    y = x;
    for (int j = 0; j < 6; j++) y = y ^ rotr(y, (a << j) % 64) ^ rotr(y, (b << j) % 64);
    return y;
  endfunction
endpackage

// File: rtl/ascon_inv_permutation_round.sv
// ascon_inv_permutation_round: one combinational inverse Ascon round
// state_i: 320-bit state in, ck_i: round constant, state_o: state after the inverse round.
module ascon_inv_permutation_round
  import ascon_inv_permutation_pkg::*;
(
  input  state_t     state_i,
  input  logic [7:0] ck_i,
  output state_t     state_o
);
  logic [63:0] lw [5];
  logic [63:0] sw [5];
  logic [4:0]  v;
  always_comb begin
    lw = '{default: '0};
    sw = '{default: '0};
    v = '0;
    for (int w = 0; w < 5; w++) lw[w] = lin_inv(state_i[319-64*w -: 64], ROT_A[w], ROT_B[w]);
    for (int i = 0; i < 64; i++) begin
      v = sbox_inv({lw[0][i], lw[1][i], lw[2][i], lw[3][i], lw[4][i]});
      for (int w = 0; w < 5; w++) sw[w][i] = v[4-w];
    end
    sw[2][7:0] = sw[2][7:0] ^ ck_i;
    state_o = {sw[0], sw[1], sw[2], sw[3], sw[4]};
  end
endmodule

// File: rtl/ascon_inv_permutation.sv
// ascon_inv_permutation: iterative inverse Ascon permutation, one inverse round per clock
// Handshake in: in_valid/in_ready with state_in (320b) and rounds_in (clamped to 12).
// Handshake out: out_valid/out_ready with state_out (always the state register).
// ASCON_INV_ZEROIZE_EN: clear the state register when the result is consumed.
module ascon_inv_permutation
  import ascon_inv_permutation_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [319:0] state_in,
  input  logic [3:0]   rounds_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [319:0] state_out
);
  fsm_t       fsm_q;
  state_t     state_q, state_d;
  logic [3:0] k_q, n_q;
  logic       in_ready_q, out_valid_q;
  logic [7:0] ck;
  // Inverse round k undoes forward round 11-k.
  assign ck = rc(4'd11 - k_q);
  ascon_inv_permutation_round u_round (
    .state_i(state_q),
    .ck_i   (ck),
    .state_o(state_d)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      k_q         <= '0;
      n_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (fsm_q)
        IDLE: if (in_valid) begin
          state_q    <= state_in;
          n_q        <= rounds_in > 4'd12 ? 4'd12 : rounds_in;
          k_q        <= '0;
          fsm_q      <= RUN;
          in_ready_q <= 1'b0;
        end
        RUN: begin
          // n=0 spends its one RUN cycle without touching the state.
          if (n_q != 4'd0) begin
            state_q <= state_d;
            k_q     <= k_q + 4'd1;
          end
          if (n_q == 4'd0 || k_q == n_q - 4'd1) begin
            fsm_q       <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: if (out_ready) begin
          fsm_q       <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
`ifdef ASCON_INV_ZEROIZE_EN
          state_q     <= '0;
`endif
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign state_out = state_q;
endmodule

// File: tb/tb_ascon_inv_permutation.sv
// tb_ascon_inv_permutation: directed self-checking bench for ascon_inv_permutation
module tb_ascon_inv_permutation;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [319:0] state_in = '0;
  logic [3:0]   rounds_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [319:0] state_out;
  int n_cmp = 0;
  int n_err = 0;

  ascon_inv_permutation dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .state_in (state_in),
    .rounds_in(rounds_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .state_out(state_out)
  );

  always #5 clk = ~clk;

  localparam logic [4:0] SBOX_F [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
  localparam int RA [5] = '{19, 61, 1, 10, 7};
  localparam int RB [5] = '{28, 39, 6, 17, 41};

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    logic [127:0] d;
    d = {x, x} >> n;
    return d[63:0];
  endfunction

  function automatic logic [319:0] fwd_round(input logic [319:0] x, input logic [7:0] c);
    logic [63:0] s [5];
    logic [63:0] t [5];
    logic [4:0]  v;
    for (int w = 0; w < 5; w++) s[w] = x[319-64*w -: 64];
    s[2][7:0] = s[2][7:0] ^ c;
    for (int i = 0; i < 64; i++) begin
      v = SBOX_F[{s[0][i], s[1][i], s[2][i], s[3][i], s[4][i]}];
      for (int w = 0; w < 5; w++) t[w][i] = v[4-w];
    end
    for (int w = 0; w < 5; w++) t[w] = t[w] ^ ror(t[w], RA[w]) ^ ror(t[w], RB[w]);
    return {t[0], t[1], t[2], t[3], t[4]};
  endfunction

  // Last nr rounds of the forward p^12 schedule.
  function automatic logic [319:0] fwd_perm(input logic [319:0] x, input int nr);
    logic [319:0] y;
    y = x;
    for (int r = 12 - nr; r < 12; r++) y = fwd_round(y, 8'hf0 - 8'(r * 15));
    return y;
  endfunction

  function automatic logic [319:0] rand320();
    logic [319:0] x;
    x = '0;
    for (int i = 0; i < 10; i++) x = {x[287:0], 32'($urandom)};
    return x;
  endfunction

  // Issues one request; lat counts edges from acceptance to out_valid (capped at 40).
  task automatic do_req(input logic [319:0] x, input logic [3:0] r, input bit ack,
                        output logic [319:0] y, output int lat);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL in_ready_timeout: in_ready=%b required 1", in_ready);
    end
    state_in = x;
    rounds_in = r;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
    y = state_out;
    if (ack) begin
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    n_cmp++; if (state_out !== 320'b0) begin n_err++; $display("FAIL reset_state_out: got %h required 0", state_out); end
  endtask

  task automatic test_single_round();
    logic [319:0] y;
    int lat;
    do_req(fwd_round('0, 8'h4b), 4'd1, 1'b1, y, lat);
    n_cmp++; if (y !== 320'b0) begin n_err++; $display("FAIL single_result: got %h required 0", y); end
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL single_latency: got %0d required 1", lat); end
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL single_return_idle: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid); end
  endtask

  task automatic test_pa();
    logic [319:0] x, y;
    int lat;
    x = rand320();
    do_req(fwd_perm(x, 12), 4'd12, 1'b1, y, lat);
    n_cmp++; if (y !== x) begin n_err++; $display("FAIL pa_result: got %h required %h", y, x); end
    n_cmp++; if (lat !== 12) begin n_err++; $display("FAIL pa_latency: got %0d required 12", lat); end
  endtask

  task automatic test_pb_clamp();
    logic [319:0] x, y;
    int lat;
    x = rand320();
    do_req(fwd_perm(x, 6), 4'd6, 1'b1, y, lat);
    n_cmp++; if (y !== x) begin n_err++; $display("FAIL pb_result: got %h required %h", y, x); end
    n_cmp++; if (lat !== 6) begin n_err++; $display("FAIL pb_latency: got %0d required 6", lat); end
    x = rand320();
    do_req(fwd_perm(x, 12), 4'd15, 1'b1, y, lat);
    n_cmp++; if (y !== x) begin n_err++; $display("FAIL clamp15_result: got %h required %h", y, x); end
    n_cmp++; if (lat !== 12) begin n_err++; $display("FAIL clamp15_latency: got %0d required 12", lat); end
    x = rand320();
    do_req(x, 4'd0, 1'b1, y, lat);
    n_cmp++; if (y !== x) begin n_err++; $display("FAIL zero_rounds_result: got %h required %h", y, x); end
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL zero_rounds_latency: got %0d required 1", lat); end
  endtask

  task automatic test_backpressure();
    logic [319:0] x, y, y2;
    int lat;
    x = rand320();
    do_req(fwd_perm(x, 3), 4'd3, 1'b0, y, lat);
    n_cmp++; if (y !== x) begin n_err++; $display("FAIL bp_result: got %h required %h", y, x); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      state_in = ~x;
      rounds_in = 4'd0;
      #1;
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_out_valid_hold: cycle %0d got %b required 1", c, out_valid); end
      n_cmp++; if (state_out !== x) begin n_err++; $display("FAIL bp_state_hold: cycle %0d got %h required %h", c, state_out, x); end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready: cycle %0d got %b required 0", c, in_ready); end
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready); end
    x = rand320();
    do_req(fwd_perm(x, 2), 4'd2, 1'b1, y2, lat);
    n_cmp++; if (y2 !== x) begin n_err++; $display("FAIL bp_after_result: got %h required %h", y2, x); end
  endtask

  task automatic test_drop();
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    state_in = rand320();
    rounds_in = 4'd12;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || state_out !== 320'b0) begin n_err++; $display("FAIL drop_async_reset: in_ready=%b out_valid=%b state_out=%h required 1/0/0", in_ready, out_valid, state_out); end
    @(negedge clk) rst = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1 if (out_valid) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL drop_no_result: out_valid seen=%b required 0", seen); end
  endtask

  task automatic test_zeroize();
    logic [319:0] x, y, exp;
    int lat;
    x = rand320();
    do_req(fwd_perm(x, 4), 4'd4, 1'b1, y, lat);
    n_cmp++; if (y !== x) begin n_err++; $display("FAIL zeroize_result: got %h required %h", y, x); end
`ifdef ASCON_INV_ZEROIZE_EN
    exp = '0;
`else
    exp = x;
`endif
    n_cmp++; if (state_out !== exp) begin n_err++; $display("FAIL zeroize_idle_state: got %h required %h", state_out, exp); end
  endtask

  task automatic test_back_to_back();
    logic [319:0] a, b, ya, yb;
    int la, lb;
    a = rand320();
    b = rand320();
    do_req(fwd_perm(a, 12), 4'd12, 1'b1, ya, la);
    do_req(fwd_perm(b, 1), 4'd1, 1'b1, yb, lb);
    n_cmp++; if (ya !== a) begin n_err++; $display("FAIL b2b_first: got %h required %h", ya, a); end
    n_cmp++; if (yb !== b) begin n_err++; $display("FAIL b2b_second: got %h required %h", yb, b); end
    n_cmp++; if (lb !== 1) begin n_err++; $display("FAIL b2b_second_latency: got %0d required 1", lb); end
  endtask

  initial begin
    test_reset();
    test_single_round();
    test_pa();
    test_pb_clamp();
    test_backpressure();
    test_drop();
    test_zeroize();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
